inst_sequencer: RTL

- Hardware instruction issuer for SYSTOLIC_ARRAY. It replaces the host/bench role of stepping instructions into the array.
- Holds a writable program memory of instruction words. On start, it walks the program and presents each word on the array's instruction input.
- It advances one word per flag handshake: flag rises, then flag falls.
- After the last word it drains with IDLE_INST, then reports done.

---
 rtl/inst_sequencer_if.sv | 31 +++
 rtl/inst_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/inst_sequencer_if.sv
// rtl/inst_sequencer_if.sv - program-load, control and array-handshake bundle for inst_sequencer
// master = host/array side, slave = sequencer side.
interface inst_sequencer_if #(
  parameter int INST_BITS      = 64,
  parameter int PROG_ADDR_BITS = 8,
  parameter int CNT_BITS       = 16
);
  logic                      prog_wen;
  logic [PROG_ADDR_BITS-1:0] prog_waddr;
  logic [INST_BITS:0]        prog_wdata;
  logic                      start;
  logic [PROG_ADDR_BITS-1:0] start_addr;
  logic                      abort;
  logic                      flag;
  logic                      idle_flag;
  logic [INST_BITS-1:0]      instruction;
  logic                      busy;
  logic                      done;
  logic [PROG_ADDR_BITS-1:0] pc;
  logic [CNT_BITS-1:0]       issued_cnt;

  modport master (
    output prog_wen, prog_waddr, prog_wdata, start, start_addr, abort, flag, idle_flag,
    input  instruction, busy, done, pc, issued_cnt
  );

  modport slave (
    input  prog_wen, prog_waddr, prog_wdata, start, start_addr, abort, flag, idle_flag,
    output instruction, busy, done, pc, issued_cnt
  );
endinterface

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - program-memory instruction issuer for the systolic array
// Steps one stored word per flag rise/fall handshake, then drains with IDLE_INST_VAL.
module inst_sequencer #(
  parameter int                   INST_BITS      = 64,
  parameter int                   PROG_DEPTH     = 256,
  parameter int                   PROG_ADDR_BITS = 8,
  parameter logic [INST_BITS-1:0] IDLE_INST_VAL  = '0,
  parameter int                   CNT_BITS       = 16
) (
  input logic             clk,
  input logic             reset_n,
  inst_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_FALL, S_SYNC, S_DRAIN, S_DRAIN_FALL
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [PROG_ADDR_BITS-1:0] r_pc, w_pc_nxt;
  logic [INST_BITS-1:0]      r_instr, w_instr_nxt;
  logic [CNT_BITS-1:0]       r_cnt, w_cnt_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      r_done, w_done_nxt;
  logic                      r_first, w_first_nxt;
  logic                      r_last, w_last_nxt;
  logic                      w_advance;
  logic [INST_BITS:0]        r_mem [PROG_DEPTH];
  logic [INST_BITS:0]        r_rdata;

  // Read-first: the read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (bus.prog_wen) r_mem[bus.prog_waddr] <= bus.prog_wdata;
    r_rdata <= r_mem[r_pc];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= IDLE_INST_VAL;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_first <= w_first_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_first_nxt = r_first;
    w_last_nxt  = r_last;
    w_advance   = 1'b0;

    if (bus.abort && r_state != S_IDLE) begin
      w_instr_nxt = IDLE_INST_VAL;
      w_busy_nxt  = 1'b0;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            w_pc_nxt    = bus.start_addr;
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_first_nxt = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
        S_FETCH: w_state_nxt = S_LATCH;
        S_LATCH: begin
          w_instr_nxt = r_rdata[INST_BITS-1:0];
          w_last_nxt  = r_rdata[INST_BITS];
          w_state_nxt = S_ISSUE;
        end
        S_ISSUE: if (bus.flag) w_state_nxt = S_WAIT_FALL;
        S_WAIT_FALL: begin
          if (!bus.flag) begin
            w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
            if (r_first) w_state_nxt = S_SYNC;
            else         w_advance   = 1'b1;
          end
        end
        // The array only leaves idle after consuming its first word.
        S_SYNC: begin
          if (!bus.idle_flag) begin
            w_first_nxt = 1'b0;
            w_advance   = 1'b1;
          end
        end
        S_DRAIN: if (bus.flag) w_state_nxt = S_DRAIN_FALL;
        S_DRAIN_FALL: begin
          if (!bus.flag) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_advance) begin
        if (r_last) begin
          w_instr_nxt = IDLE_INST_VAL;
          w_state_nxt = S_DRAIN;
        end else begin
          w_pc_nxt    = r_pc + 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
    end
  end

  assign bus.instruction = r_instr;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pc          = r_pc;
  assign bus.issued_cnt  = r_cnt;
endmodule
